// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and size helpers for the dot-product sequencer.
package dps_pkg;

    localparam int DEF_LANES    = 16;
    localparam int DEF_A_DEPTH  = 4096;
    localparam int DEF_B_DEPTH  = 64;
    localparam int DEF_PIPE_LAT = 2;
    localparam int DEF_CNT_W    = 16;

    // Wide enough for any practical row index; the top truncates to its own width.
    localparam int TAG_ROW_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 first;
        logic                 last;
        logic [TAG_ROW_W-1:0] row;
    } tag_t;

    function automatic int bpr(input int b_depth, input int lanes);
        return b_depth / lanes;
    endfunction

    function automatic int nbeats(input int a_depth, input int lanes);
        return a_depth / lanes;
    endfunction

    function automatic int nrows(input int a_depth, input int b_depth);
        return a_depth / b_depth;
    endfunction

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_BPR    = bpr(DEF_B_DEPTH, DEF_LANES);
    localparam int DEF_NBEATS = nbeats(DEF_A_DEPTH, DEF_LANES);
    localparam int DEF_NROWS  = nrows(DEF_A_DEPTH, DEF_B_DEPTH);

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Start/status and ROM/accumulator control bundle; stall exists only with SEQ_STALL_EN.
interface dot_product_sequencer_if
    import dps_pkg::*;
#(
    parameter int A_DEPTH = DEF_A_DEPTH,
    parameter int B_DEPTH = DEF_B_DEPTH,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int AW = width_of(A_DEPTH);
    localparam int BW = width_of(B_DEPTH);
    localparam int RW = width_of(A_DEPTH / B_DEPTH);

    logic             start;
`ifdef SEQ_STALL_EN
    logic             stall;
`endif
    logic [AW-1:0]    romA_addr;
    logic [BW-1:0]    romB_addr;
    logic             acc_en;
    logic             acc_first;
    logic             row_valid;
    logic [RW-1:0]    row_idx;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_count;

    // master: the sequencer; slave: wrapper plus ROM/accumulator datapath
    modport master (
`ifdef SEQ_STALL_EN
        input  stall,
`endif
        input  start,
        output romA_addr, romB_addr, acc_en, acc_first,
        output row_valid, row_idx, busy, done, cycle_count
    );

    modport slave (
`ifdef SEQ_STALL_EN
        output stall,
`endif
        output start,
        input  romA_addr, romB_addr, acc_en, acc_first,
        input  row_valid, row_idx, busy, done, cycle_count
    );

endinterface

// File: rtl/dps_valid_pipe.sv
// DEPTH-stage shift register carrying beat tags alongside the ROM/operand pipeline.
module dps_valid_pipe
    import dps_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic clock,
    input  logic reset_l,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            // NOTE: every stage is reset, not just the head, so no stale valid escapes after reset.
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dot_product_sequencer.sv
// Sequences ROM addresses and accumulator controls for a 64x64 by 64 dot product.
// Optional SEQ_STALL_EN adds a stall input that freezes beat issue in FETCH.
module dot_product_sequencer
    import dps_pkg::*;
#(
    parameter int LANES    = DEF_LANES,
    parameter int A_DEPTH  = DEF_A_DEPTH,
    parameter int B_DEPTH  = DEF_B_DEPTH,
    parameter int PIPE_LAT = DEF_PIPE_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic                     clock,
    input logic                     reset_l,
    dot_product_sequencer_if.master bus
);

    localparam int BPR    = bpr(B_DEPTH, LANES);
    localparam int NBEATS = nbeats(A_DEPTH, LANES);
    localparam int NROWS  = nrows(A_DEPTH, B_DEPTH);
    localparam int AW     = width_of(A_DEPTH);
    localparam int BW     = width_of(B_DEPTH);
    localparam int RW     = width_of(NROWS);
    localparam int BEAT_W = width_of(NBEATS);
    localparam int COL_W  = width_of(BPR);
    localparam int DRN_W  = width_of(PIPE_LAT + 1);

    state_e           state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [AW-1:0]     a_addr_q, a_addr_d;
    logic [BW-1:0]     b_addr_q, b_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, done_q, row_valid_q;
    logic [RW-1:0]     row_idx_q;
    logic              stall;
    tag_t              tag_in, tag_out;

`ifdef SEQ_STALL_EN
    assign stall = bus.stall;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d  = state_q;
        beat_d   = beat_q;
        col_d    = col_q;
        row_d    = row_q;
        drain_d  = drain_q;
        a_addr_d = a_addr_q;
        b_addr_d = b_addr_q;
        cnt_d    = cnt_q;
        tag_in   = '0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = FETCH;
                    beat_d   = '0;
                    col_d    = '0;
                    row_d    = '0;
                    a_addr_d = '0;
                    b_addr_d = '0;
                    cnt_d    = '0;
                end
            end
            FETCH: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (!stall) begin
                    tag_in.valid = 1'b1;
                    tag_in.first = (col_q == '0);
                    tag_in.last  = (col_q == COL_W'(BPR - 1));
                    tag_in.row   = TAG_ROW_W'(row_q);
                    if (beat_q == BEAT_W'(NBEATS - 1)) begin
                        state_d  = DRAIN;
                        drain_d  = '0;
                        a_addr_d = '0;
                        b_addr_d = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        if (col_q == COL_W'(BPR - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        a_addr_d = AW'(int'(beat_d) * LANES);
                        b_addr_d = BW'(int'(col_d) * LANES);
                    end
                end
            end
            DRAIN: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                if (drain_q == DRN_W'(PIPE_LAT)) state_d = DONE;
                else                             drain_d = drain_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    dps_valid_pipe #(.DEPTH(PIPE_LAT)) u_pipe (
        .clock   (clock),
        .reset_l (reset_l),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            drain_q     <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            beat_q      <= beat_d;
            col_q       <= col_d;
            row_q       <= row_d;
            drain_q     <= drain_d;
            a_addr_q    <= a_addr_d;
            b_addr_q    <= b_addr_d;
            cnt_q       <= cnt_d;
            busy_q      <= (state_d == FETCH) || (state_d == DRAIN);
            done_q      <= (state_d == DONE);
            row_valid_q <= tag_out.valid & tag_out.last;
            if (tag_out.valid & tag_out.last) row_idx_q <= RW'(tag_out.row);
        end
    end

    // Tag fields are only set on injected beats, so first needs no valid qualifier.
    assign bus.romA_addr   = a_addr_q;
    assign bus.romB_addr   = b_addr_q;
    assign bus.acc_en      = tag_out.valid;
    assign bus.acc_first   = tag_out.first;
    assign bus.row_valid   = row_valid_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer; cycle 0 is the cycle in which start is driven.
module tb_dot_product_sequencer;

    logic clock;
    logic reset_l;
    logic stall_req;

    int n_asserts = 0;
    int n_fail    = 0;

    bit   acc_en_at   [0:399];
    bit   acc_first_at[0:399];
    int   rv_cycle    [0:63];
    logic [11:0] a_at [0:8];
    logic [5:0]  b_at [0:8];
    int rv_count, n_acc, n_first, first_acc, last_acc;
    int done_cycle, busy_fall, cnt_at_done, cnt_c1, done_c1;

    dot_product_sequencer_if #(.A_DEPTH(4096), .B_DEPTH(64), .CNT_W(16)) bus ();

    dot_product_sequencer #(
        .LANES(16), .A_DEPTH(4096), .B_DEPTH(64), .PIPE_LAT(2), .CNT_W(16)
    ) dut (
        .clock   (clock),
        .reset_l (reset_l),
        .bus     (bus)
    );

`ifdef SEQ_STALL_EN
    assign bus.stall = stall_req;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(bus.busy),        32'h0);
        check({tag, "_done"},      32'(bus.done),        32'h0);
        check({tag, "_acc_en"},    32'(bus.acc_en),      32'h0);
        check({tag, "_acc_first"}, 32'(bus.acc_first),   32'h0);
        check({tag, "_row_valid"}, 32'(bus.row_valid),   32'h0);
        check({tag, "_romA"},      32'(bus.romA_addr),   32'h0);
        check({tag, "_romB"},      32'(bus.romB_addr),   32'h0);
        check({tag, "_row_idx"},   32'(bus.row_idx),     32'h0);
        check({tag, "_count"},     32'(bus.cycle_count), 32'h0);
    endtask

    // Starts a run in the current cycle and records events until done rises.
    task automatic run(input int s1, input int s2, input int st_lo, input int st_hi);
        for (int i = 0; i < 400; i++) begin
            acc_en_at[i]    = 1'b0;
            acc_first_at[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) rv_cycle[i] = -1;
        rv_count = 0; n_acc = 0; n_first = 0; first_acc = -1; last_acc = -1;
        done_cycle = -1; busy_fall = -1; cnt_at_done = -1; cnt_c1 = -1; done_c1 = -1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 400 && done_cycle < 0; c++) begin
            if (c <= 8) begin
                a_at[c] = bus.romA_addr;
                b_at[c] = bus.romB_addr;
            end
            if (c == 1) begin
                cnt_c1  = int'(bus.cycle_count);
                done_c1 = int'(bus.done);
            end
            if (bus.acc_en) begin
                acc_en_at[c] = 1'b1;
                n_acc++;
                if (first_acc < 0) first_acc = c;
                last_acc = c;
            end
            if (bus.acc_first) begin
                acc_first_at[c] = 1'b1;
                n_first++;
            end
            if (bus.row_valid) begin
                rv_count++;
                rv_cycle[bus.row_idx] = c;
            end
            if (!bus.busy && busy_fall < 0) busy_fall = c;
            if (bus.done) begin
                done_cycle  = c;
                cnt_at_done = int'(bus.cycle_count);
            end
            bus.start = (c == s1) || (c == s2);
            stall_req = (c >= st_lo) && (c <= st_hi);
            if (done_cycle < 0) tick();
        end
        bus.start = 1'b0;
        stall_req = 1'b0;
    endtask

    task automatic check_baseline(input string tag);
        check({tag, "_romA_c1"},      32'(a_at[1]),         32'h000);
        check({tag, "_romA_c2"},      32'(a_at[2]),         32'h010);
        check({tag, "_romA_c3"},      32'(a_at[3]),         32'h020);
        check({tag, "_romB_c1"},      32'(b_at[1]),         32'h00);
        check({tag, "_romB_c2"},      32'(b_at[2]),         32'h10);
        check({tag, "_romB_c3"},      32'(b_at[3]),         32'h20);
        check({tag, "_romB_c4"},      32'(b_at[4]),         32'h30);
        check({tag, "_romB_c5"},      32'(b_at[5]),         32'h00);
        check({tag, "_count_c1"},     32'(cnt_c1),          32'h0);
        check({tag, "_done_c1"},      32'(done_c1),         32'h0);
        check({tag, "_first_acc"},    32'(first_acc),       32'd3);
        check({tag, "_acc_first_c3"}, 32'(acc_first_at[3]), 32'h1);
        check({tag, "_acc_first_c4"}, 32'(acc_first_at[4]), 32'h0);
        check({tag, "_acc_first_c7"}, 32'(acc_first_at[7]), 32'h1);
        check({tag, "_n_acc"},        32'(n_acc),           32'd256);
        check({tag, "_n_first"},      32'(n_first),         32'd64);
        check({tag, "_rv_count"},     32'(rv_count),        32'd64);
        check({tag, "_rv0_cycle"},    32'(rv_cycle[0]),     32'd7);
        check({tag, "_rv1_cycle"},    32'(rv_cycle[1]),     32'd11);
        check({tag, "_rv63_cycle"},   32'(rv_cycle[63]),    32'd259);
        check({tag, "_busy_fall"},    32'(busy_fall),       32'd260);
        check({tag, "_done_cycle"},   32'(done_cycle),      32'd260);
        check({tag, "_count_done"},   32'(cnt_at_done),     32'h0103);
    endtask

    initial begin
        reset_l   = 1'b0;
        bus.start = 1'b0;
        stall_req = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        reset_l = 1'b1;
        repeat (2) tick();
        check_all_zero("idle");

        // Baseline run, then done and the count must hold in DONE
        run(-1, -1, 0, -1);
        check_baseline("base");
        repeat (3) tick();
        check("hold_done",  32'(bus.done),        32'h1);
        check("hold_busy",  32'(bus.busy),        32'h0);
        check("hold_count", 32'(bus.cycle_count), 32'h0103);
        check("hold_romA",  32'(bus.romA_addr),   32'h0);

        // Restart from DONE with extra starts mid-run that must be ignored
        run(50, 100, 0, -1);
        check_baseline("restart");

        // Asynchronous reset in the middle of a run
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (119) tick();
        check("midrun_busy", 32'(bus.busy), 32'h1);
        reset_l = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clock);
        #1;
        reset_l = 1'b1;
        tick();
        check_all_zero("post_reset");
        run(-1, -1, 0, -1);
        check_baseline("after_reset");

`ifdef SEQ_STALL_EN
        run(-1, -1, 10, 14);
        check("stall_n_acc",      32'(n_acc),                          32'd256);
        check("stall_gaps",       32'((last_acc - first_acc + 1) - n_acc), 32'd5);
        check("stall_acc_c11",    32'(acc_en_at[11]),                  32'h1);
        check("stall_acc_c12",    32'(acc_en_at[12]),                  32'h0);
        check("stall_acc_c17",    32'(acc_en_at[17]),                  32'h1);
        check("stall_rv63_cycle", 32'(rv_cycle[63]),                   32'd264);
        check("stall_count",      32'(cnt_at_done),                    32'h0108);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Controller for the 16-lane multiply/adder-tree datapath. It sequences ROM A and ROM B base addresses, tracks beats through the ROM and operand-register pipeline, and drives the accumulator controls (load/add). It emits one result strobe per 64-element row dot product of A (64x64) with B (64) and reports done plus a cycle count. It sits between a top-level start/display wrapper and the existing ROMs, registers, multipliers and adder tree.

Parameters:
LANES, 16, elements fetched per beat (ROM address stride); power of two.
A_DEPTH, 4096, total ROM A words; multiple of B_DEPTH.
B_DEPTH, 64, ROM B words (= row length); multiple of LANES.
PIPE_LAT, 2, cycles from address issue to multiplier inputs (ROM read + operand register).
CNT_W, 16, cycle counter width.

Ports:
clock  in  1  system clock
reset_l  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled on rising edge
romA_addr  out  $clog2(A_DEPTH)  ROM A base address; lane i reads romA_addr+i
romB_addr  out  $clog2(B_DEPTH)  ROM B base address; lane i reads romB_addr+i
acc_en  out  1  accumulator update this cycle
acc_first  out  1  with acc_en: load tree sum instead of add (first beat of row)
row_valid  out  1  one-cycle strobe: accumulator holds finished row result
row_idx  out  $clog2(A_DEPTH/B_DEPTH)  row number for row_valid
busy  out  1  run in progress
done  out  1  run complete; held until next accepted start
cycle_count  out  CNT_W  busy-cycle count for last/current run

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. On reset_l low, all outputs are 0, the state is IDLE, and the valid pipe is cleared, regardless of any run in progress.
- Derived constants: BPR = B_DEPTH/LANES (4 beats per row); NBEATS = A_DEPTH/LANES (256 beats); NROWS = A_DEPTH/B_DEPTH (64 rows).
- States:
  - IDLE: start=1 -> FETCH. Also clears cycle_count, beat, row, and done.
  - FETCH: issues one beat per cycle.
    - romA_addr = beat*LANES.
    - romB_addr = (beat mod BPR)*LANES.
    - After the beat with index NBEATS-1 -> DRAIN.
  - DRAIN: lasts PIPE_LAT+1 cycles, then -> DONE. Addresses return to 0.
  - DONE: start=1 -> FETCH (same actions as from IDLE). Otherwise holds.
- start handling: start is ignored while busy (FETCH/DRAIN).
- Cycle timing: the start-accept edge ends cycle 0, so beat b is driven in cycle b+1.
- Valid pipe: PIPE_LAT-deep shift of {valid, first, last, row}.
  - Beat b produces acc_en in cycle b+1+PIPE_LAT.
  - acc_first=1 when b mod BPR == 0.
  - row_valid pulses the cycle after a last-of-row beat's acc_en, with row_idx = b/BPR.
- busy = FETCH or DRAIN.
- done = DONE, registered.
- cycle_count increments every busy cycle and saturates at all-ones. It freezes in DONE.
- Address arithmetic is truncating; the beat counter never wraps mid-run.
- acc_first and row_valid are never asserted without their qualifying beat. Outputs are glitch-free registered signals.

Optional Feature:
SEQ_STALL_EN: adds a 1-bit input port stall.
- With the macro:
  - stall=1 in FETCH holds beat, addresses and cycle_count increment as normal.
  - No new valid is injected into the pipe; beats already in flight drain normally.
  - stall is ignored in other states.
- Without the macro: the port is absent and the block never stalls.

Decomposition:
Package dps_pkg holds:
- state enum (IDLE, FETCH, DRAIN, DONE);
- the pipe-tag struct {valid, first, last, row};
- localparam helpers for BPR, NBEATS and NROWS.

Sub-module: dps_valid_pipe, a parameterized PIPE_LAT-deep tag shift register with async active-low reset.

Test Plan:
- Reset then a start pulse at cycle 0, defaults:
  - romA_addr = 0x000, 0x010, 0x020 in cycles 1-3;
  - romB_addr = 0x00, 0x10, 0x20, 0x30, 0x00 in cycles 1-5.
- Same run:
  - first acc_en with acc_first=1 at cycle 3;
  - acc_first again at cycle 7;
  - row_valid row_idx=0 at cycle 7, row_idx=63 at cycle 259;
  - busy falls and done rises at cycle 260;
  - cycle_count = 0x0103.
- start pulsed at cycles 50 and 100 during a run -> both ignored; the run timing is identical to the baseline.
- reset_l low at cycle 120 -> all outputs 0 immediately; the next start begins at romA_addr 0 and cycle_count 0.
- start in DONE -> done clears next cycle; the second run reproduces the baseline with cycle_count 0x0103.
- SEQ_STALL_EN with stall high for cycles 10-14 -> 5 acc_en gaps; last row_valid at cycle 264; cycle_count = 0x0108.
